// File: rtl/ann_ctrl_pkg.sv
// rtl/ann_ctrl_pkg.sv - shared state encoding and loader command constants for ann_ctrl
package ann_ctrl_pkg;

    localparam int ROW_W = 7;

    typedef enum logic [2:0] {
        WAIT_IMG,
        CLR_ACC,
        REQ_COEF,
        COMPUTE,
        STORE,
        DONE
    } state_t;

    localparam logic [1:0] LN_IDLE  = 2'b00;
    localparam logic [1:0] LN_IMAGE = 2'b01;
    localparam logic [1:0] LN_COEF  = 2'b10;
    localparam logic [1:0] LN_STORE = 2'b11;

endpackage

// File: rtl/ann_row_counter.sv
// rtl/ann_row_counter.sv - coefficient row index with clear/enable and last-row flag
module ann_row_counter
    import ann_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [ROW_W-1:0] max_input_i,
    output logic [ROW_W-1:0] count_o,
    output logic             is_last_o
);

    logic [ROW_W-1:0] count_q;
    logic [ROW_W-1:0] count_d;

    // Saturates at all-ones: the row index must never wrap back to 0.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + ROW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign is_last_o = (count_q == (max_input_i - ROW_W'(1)));

endmodule

// File: rtl/ann_ctrl.sv
// rtl/ann_ctrl.sv - ANN accelerator row sequencer; optional wait-state watchdog via ANN_CTRL_TIMEOUT_EN
module ann_ctrl
    import ann_ctrl_pkg::*;
`ifdef ANN_CTRL_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 1024
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             image_weights_loaded,
    input  logic             n_start_done,
    input  logic [ROW_W-1:0] max_input,
    output logic             coeff_ready,
    output logic             reset_accum,
    output logic [1:0]       load_next,
    output logic             request_coef,
    output logic             done_processing,
    output logic [ROW_W-1:0] coef_select
`ifdef ANN_CTRL_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    state_t state_q;
    state_t state_d;
    logic   row_clr;
    logic   row_en;
    logic   row_last;

`ifdef ANN_CTRL_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic [15:0] tmo_cnt_d;
    logic        timeout_q;
    logic        timeout_d;
    logic        in_wait;

    assign in_wait = (state_q == WAIT_IMG) || (state_q == REQ_COEF) ||
                     (state_q == COMPUTE)  || (state_q == STORE);
`endif

    ann_row_counter u_row_counter (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (row_clr),
        .en_i        (row_en),
        .max_input_i (max_input),
        .count_o     (coef_select),
        .is_last_o   (row_last)
    );

    always_comb begin
        state_d = state_q;
        row_clr = 1'b0;
        row_en  = 1'b0;
`ifdef ANN_CTRL_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            WAIT_IMG: if (image_weights_loaded) state_d = (max_input == '0) ? DONE : CLR_ACC;
            CLR_ACC:  state_d = REQ_COEF;
            REQ_COEF: if (image_weights_loaded) state_d = COMPUTE;
            COMPUTE:  if (n_start_done) state_d = STORE;
            STORE: begin
                if (image_weights_loaded) begin
                    if (row_last) begin
                        state_d = DONE;
                    end else begin
                        row_en  = 1'b1;
                        state_d = CLR_ACC;
                    end
                end
            end
            DONE: begin
                if (image_weights_loaded) begin
                    row_clr = 1'b1;
                    state_d = CLR_ACC;
                end
            end
            default: state_d = WAIT_IMG;
        endcase
`ifdef ANN_CTRL_TIMEOUT_EN
        // A real event in the same cycle wins over the watchdog.
        if ((state_d == state_q) && in_wait && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1))) begin
            state_d   = DONE;
            timeout_d = 1'b1;
        end
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (in_wait) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_IMG;
`ifdef ANN_CTRL_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef ANN_CTRL_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        coeff_ready     = 1'b0;
        reset_accum     = 1'b0;
        load_next       = LN_IDLE;
        request_coef    = 1'b0;
        done_processing = 1'b0;
        case (state_q)
            WAIT_IMG: load_next = LN_IMAGE;
            CLR_ACC:  reset_accum = 1'b1;
            REQ_COEF: begin
                request_coef = 1'b1;
                load_next    = LN_COEF;
            end
            COMPUTE:  coeff_ready = 1'b1;
            STORE:    load_next = LN_STORE;
            DONE:     done_processing = 1'b1;
            default:  load_next = LN_IDLE;
        endcase
    end

`ifdef ANN_CTRL_TIMEOUT_EN
    assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_ann_ctrl.sv
// tb/tb_ann_ctrl.sv - self-checking bench for ann_ctrl: reference model plus directed and random stimulus
module tb_ann_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iwl = 1'b0;
    logic       nsd = 1'b0;
    logic [6:0] max_input = 7'd0;
    logic       coeff_ready, reset_accum, request_coef, done_processing;
    logic [1:0] load_next;
    logic [6:0] coef_select;
`ifdef ANN_CTRL_TIMEOUT_EN
    logic       timeout;
    localparam int TMO = 8;
`endif

    int tests = 0;
    int fails = 0;
    int racc_pulses = 0;
    bit req_seen = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

`ifdef ANN_CTRL_TIMEOUT_EN
    ann_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
`else
    ann_ctrl dut (
`endif
        .clk                  (clk),
        .rst                  (rst),
        .image_weights_loaded (iwl),
        .n_start_done         (nsd),
        .max_input            (max_input),
        .coeff_ready          (coeff_ready),
        .reset_accum          (reset_accum),
        .load_next            (load_next),
        .request_coef         (request_coef),
        .done_processing      (done_processing),
        .coef_select          (coef_select)
`ifdef ANN_CTRL_TIMEOUT_EN
        ,
        .timeout              (timeout)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase names as small ints, row index as plain int.
    localparam int P_IMG = 0, P_CLR = 1, P_REQ = 2, P_CMP = 3, P_STO = 4, P_DON = 5;
    int m_ph  = P_IMG;
    int m_sel = 0;
    int m_cnt = 0;
    bit m_to  = 0;

    always @(posedge clk) begin
        int nxt;
        if (rst) begin
            m_ph = P_IMG; m_sel = 0; m_cnt = 0; m_to = 0;
        end else begin
            nxt = m_ph;
            if (m_ph == P_IMG && iwl) nxt = (max_input == 0) ? P_DON : P_CLR;
            else if (m_ph == P_CLR) nxt = P_REQ;
            else if (m_ph == P_REQ && iwl) nxt = P_CMP;
            else if (m_ph == P_CMP && nsd) nxt = P_STO;
            else if (m_ph == P_STO && iwl) begin
                if (m_sel == (int'(max_input) + 127) % 128) nxt = P_DON;
                else begin
                    nxt = P_CLR;
                    if (m_sel < 127) m_sel = m_sel + 1;
                end
            end else if (m_ph == P_DON && iwl) begin
                nxt = P_CLR; m_sel = 0;
            end
`ifdef ANN_CTRL_TIMEOUT_EN
            if (nxt == m_ph && m_ph inside {P_IMG, P_REQ, P_CMP, P_STO}) begin
                if (m_cnt == TMO - 1) begin nxt = P_DON; m_to = 1; end
                else m_cnt = m_cnt + 1;
            end
            if (nxt != m_ph) m_cnt = 0;
`endif
            m_ph = nxt;
        end
    end

    always @(negedge clk) begin
        int exp_v, act_v;
        if (cmp_en) begin
            exp_v = ((m_ph == P_CMP) ? 1 : 0) << 12 | ((m_ph == P_CLR) ? 1 : 0) << 11 |
                    ((m_ph == P_IMG) ? 1 : (m_ph == P_REQ) ? 2 : (m_ph == P_STO) ? 3 : 0) << 9 |
                    ((m_ph == P_REQ) ? 1 : 0) << 8 | ((m_ph == P_DON) ? 1 : 0) << 7 | m_sel;
            act_v = int'({coeff_ready, reset_accum, load_next, request_coef, done_processing, coef_select});
`ifdef ANN_CTRL_TIMEOUT_EN
            exp_v = exp_v | (int'(m_to) << 13);
            act_v = act_v | (int'(timeout) << 13);
`endif
            check("model_cmp", act_v, exp_v);
        end
        if (reset_accum) racc_pulses++;
        if (request_coef) req_seen = 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_img();
        iwl = 1'b1; tick(); iwl = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    // From CLR_ACC: on to REQ_COEF, COMPUTE, then STORE.
    task automatic go_store();
        tick();
        pulse_img();
        nsd = 1'b1; tick(); nsd = 1'b0;
    endtask

    initial begin
        tick();
        do_reset();
        cmp_en = 1;

        // reset state held with no pulses
        repeat (5) tick();
        check("rst_load_next", int'(load_next), 1);
        check("rst_others", int'({coeff_ready, reset_accum, request_coef, done_processing}), 0);
        check("rst_coef_select", int'(coef_select), 0);

        // three rows
        max_input = 7'd3;
        racc_pulses = 0;
        pulse_img();
        check("t2_clr", int'(reset_accum), 1);
        for (int i = 0; i < 3; i++) begin
            go_store();
            check("t2_store_ln", int'(load_next), 3);
            check("t2_store_sel", int'(coef_select), i);
            pulse_img();
            if (i < 2) check("t2_next_sel", int'(coef_select), i + 1);
        end
        check("t2_done", int'(done_processing), 1);
        check("t2_done_sel", int'(coef_select), 2);
        check("t2_racc_pulses", racc_pulses, 3);

        // zero rows
        do_reset();
        max_input = 7'd0;
        req_seen = 0;
        pulse_img();
        check("t3_done", int'(done_processing), 1);
        repeat (3) tick();
        check("t3_no_req", int'(req_seen), 0);

        // stray image pulse during COMPUTE
        do_reset();
        max_input = 7'd5;
        pulse_img();
        tick();
        pulse_img();
        check("t4_compute", int'(coeff_ready), 1);
        pulse_img();
        check("t4_hold", int'(coeff_ready), 1);
        tick();
        check("t4_hold2", int'(coeff_ready), 1);

        // reset in STORE with row 2
        nsd = 1'b1; tick(); nsd = 1'b0;
        pulse_img();
        go_store(); pulse_img();
        go_store();
        check("t5_pre_sel", int'(coef_select), 2);
        check("t5_pre_ln", int'(load_next), 3);
        do_reset();
        check("t5_sel", int'(coef_select), 0);
        check("t5_ln", int'(load_next), 1);

`ifdef ANN_CTRL_TIMEOUT_EN
        max_input = 7'd2;
        pulse_img();
        tick();
        repeat (TMO - 1) tick();
        check("t6_not_yet", int'(done_processing), 0);
        tick();
        check("t6_timeout", int'(timeout), 1);
        check("t6_done", int'(done_processing), 1);
        pulse_img();
        check("t6_sticky", int'(timeout), 1);
        do_reset();
`endif

        // randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            if (c % 60 == 0) max_input = 7'($urandom_range(0, 4));
            rst = ($urandom_range(0, 199) == 0);
            iwl = ($urandom_range(0, 2) == 0);
            nsd = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b0; iwl = 1'b0; nsd = 1'b0;
        tick();
        cmp_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
